// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared state encoding and line constants for the FIFO-fed UART transmitter
package fifo_uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;
  localparam logic IDLE_LVL = 1'b1;
  localparam int NE_BIT = 0;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period cycle counter with restart and end-of-bit tick
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  // count cycles within a bit, wrapping exactly at the boundary so bit periods never drift
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO read port and sends each as an async UART frame
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [3:0]   status,
  input  logic [n-1:0] data_i,
  output logic         clk_o,
  output logic         tx,
  output logic         busy
);
  localparam int IW = $clog2(n);
  localparam logic [IW-1:0] LAST_BIT = IW'(n - 1);
  localparam logic LAST_SB = 1'(STOP_BITS - 1);
  state_t state;
  logic [n-1:0] shreg;
  logic [IW-1:0] idx;
  logic sb, tick, restart, go, unused_status;
  assign go = en && status[NE_BIT];
  assign restart = state != START && state != DATA && state != STOP;
  assign unused_status = ^status[3:1];
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .restart(restart),
    .tick(tick)
  );
  // frame sequencer: pop strobe, word capture, start/data/stop serialisation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tx    <= IDLE_LVL;
      clk_o <= 1'b0;
      busy  <= 1'b0;
      shreg <= '0;
      idx   <= '0;
      sb    <= 1'b0;
    end else begin
      clk_o <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state <= POP;
          clk_o <= 1'b1;
          busy  <= 1'b1;
        end
        POP: state <= LATCH;
        LATCH: begin
          shreg <= data_i;
          tx    <= 1'b0;
          state <= START;
        end
        START: if (tick) begin
          tx    <= shreg[0];
          idx   <= '0;
          state <= DATA;
        end
        DATA: if (tick) begin
          if (idx == LAST_BIT) begin
            tx    <= IDLE_LVL;
            sb    <= 1'b0;
            state <= STOP;
          end else begin
            shreg <= shreg >> 1;
            tx    <= shreg[1];
            idx   <= idx + 1'b1;
          end
        end
        STOP: if (tick) begin
          if (sb == LAST_SB) begin
            state <= go ? POP : IDLE;
            clk_o <= go;
            busy  <= go;
          end else sb <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two transmitters (1 and 2 stop bits) fed from modelled FIFOs, checked cycle by cycle against expected line streams
module tb_fifo_uart_tx;
  localparam int C = 4;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic [2:0] st_hi = 3'b000;
  logic [7:0] mem [2][512];
  int wr [2] = '{0, 0};
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : lane
    logic clk_o, tx, busy;
    logic [3:0] status;
    logic [7:0] data_i = 8'h00;
    int rd = 0;
    int rr = 0;
    logic en_s = 1'b0;
    logic ne_s = 1'b0;
    logic q [$];
    assign status = {st_hi, wr[g] != rd};
    fifo_uart_tx #(.n(N), .CLKS_PER_BIT(C), .STOP_BITS(g + 1)) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .status(status),
      .data_i(data_i),
      .clk_o(clk_o),
      .tx(tx),
      .busy(busy)
    );
    always @(posedge clk_o) begin
      data_i <= mem[g][rd[8:0]];
      rd <= rd + 1;
    end
    always @(posedge clk) begin
      en_s <= en;
      ne_s <= wr[g] != rr;
    end
    always @(negedge clk) begin
      logic ep, e;
      logic [7:0] w;
      if (!rst_n) begin
        q.delete();
        chk($sformatf("l%0d_rst_tx", g), 32'(tx), 32'(1));
        chk($sformatf("l%0d_rst_clk_o", g), 32'(clk_o), 32'(0));
        chk($sformatf("l%0d_rst_busy", g), 32'(busy), 32'(0));
      end else begin
        ep = q.size() == 0 && en_s && ne_s;
        chk($sformatf("l%0d_clk_o", g), 32'(clk_o), 32'(ep));
        chk($sformatf("l%0d_busy", g), 32'(busy), 32'(ep || q.size() != 0));
        e = q.size() != 0 ? q.pop_front() : 1'b1;
        chk($sformatf("l%0d_tx", g), 32'(tx), 32'(e));
        if (ep) begin
          w = mem[g][rr[8:0]];
          rr++;
          q.push_back(1'b1);
          repeat (C) q.push_back(1'b0);
          for (int k = 0; k < N; k++) begin
            repeat (C) q.push_back(w[0]);
            w = w >> 1;
          end
          repeat ((g + 1) * C) q.push_back(1'b1);
        end
      end
    end
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] w);
    for (int i = 0; i < 2; i++) begin
      mem[i][wr[i][8:0]] = w;
      wr[i]++;
    end
  endtask
  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    step();
    while ((lane[0].busy || lane[1].busy) && k < lim) begin
      step();
      k++;
    end
    chk("idle_timeout", 32'(k < lim), 32'(1));
  endtask
  initial begin
    int k;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("init_tx", 32'(lane[0].tx & lane[1].tx), 32'(1));
    chk("init_busy", 32'(lane[0].busy | lane[1].busy), 32'(0));
    rst_n = 1'b1;
    en = 1'b1;
    repeat (100) step();
    en = 1'b0;
    chk("empty_pops", 32'(lane[0].rd + lane[1].rd), 32'(0));
    push(8'hA5);
    step();
    en = 1'b1;
    step();
    en = 1'b0;
    wait_idle(200);
    chk("a5_pops0", 32'(lane[0].rd), 32'(1));
    chk("a5_pops1", 32'(lane[1].rd), 32'(1));
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    en = 1'b1;
    wait_idle(600);
    en = 1'b0;
    chk("three_pops0", 32'(lane[0].rd), 32'(4));
    chk("three_pops1", 32'(lane[1].rd), 32'(4));
    push(8'h81);
    push(8'h81);
    en = 1'b1;
    wait_idle(600);
    en = 1'b0;
    chk("stop2_pops", 32'(lane[1].rd), 32'(wr[1]));
    push(8'h11);
    push(8'h22);
    en = 1'b1;
    k = 0;
    while (!lane[0].clk_o && k < 20) begin
      step();
      k++;
    end
    chk("drop_pop_seen", 32'(lane[0].clk_o), 32'(1));
    repeat (1 + C + 3 * C + 2) step();
    en = 1'b0;
    wait_idle(300);
    chk("drop_left0", 32'(wr[0] - lane[0].rd), 32'(1));
    chk("drop_left1", 32'(wr[1] - lane[1].rd), 32'(1));
    en = 1'b1;
    wait_idle(300);
    en = 1'b0;
    push(8'hA5);
    step();
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (1 + C + 2 * C) step();
    chk("pre_rst_busy", 32'(lane[0].busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx0", 32'(lane[0].tx), 32'(1));
    chk("async_clk_o0", 32'(lane[0].clk_o), 32'(0));
    chk("async_busy0", 32'(lane[0].busy), 32'(0));
    chk("async_tx1", 32'(lane[1].tx), 32'(1));
    chk("async_busy1", 32'(lane[1].busy), 32'(0));
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      step();
      en = $urandom_range(0, 9) < 7;
      st_hi = 3'($urandom);
      if ($urandom_range(0, 31) == 0) push(8'($urandom));
    end
    en = 1'b1;
    wait_idle(8000);
    en = 1'b0;
    step();
    chk("drain0", 32'(lane[0].rd), 32'(wr[0]));
    chk("drain1", 32'(lane[1].rd), 32'(wr[1]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
